led_req_scheduler: RTL and testbench

//   Shares the board's 2-bit LED output between NUM_REQ requesters.

---
 rtl/led_pkg.sv | 13 +
 rtl/led_rr_arbiter.sv | 36 +++
 rtl/led_req_scheduler.sv | 117 +++++++++++
 tb/tb_led_req_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared FSM state type, LED constants and pattern rotation for the LED request scheduler
package led_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} led_sched_state_t;

    localparam logic [1:0] LED_IDLE = 2'b11;
    localparam logic [1:0] LED_OFF  = 2'b00;

    function automatic logic [1:0] rotl2(input logic [1:0] p);
        return {p[0], p[1]};
    endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// led_rr_arbiter: round-robin winner select from rr_ptr with wrap; LED_SCHED_PRIO_EN gives requester 0 fixed priority
module led_rr_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               valid,
    output logic               prio_win,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0] j;

    always_comb begin
        idx = '0;
        j = '0;
        // Scan from the farthest offset down so the nearest set request at/after rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[j]) idx = j;
        end
`ifdef LED_SCHED_PRIO_EN
        prio_win = req[0];
        if (prio_win) idx = '0;
`else
        prio_win = 1'b0;
`endif
        valid = |req;
        onehot = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/led_req_scheduler.sv
// led_req_scheduler: shares a 2-bit LED between requesters round-robin (LED_SCHED_PRIO_EN: requester 0 fixed priority)
module led_req_scheduler
    import led_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TICK_DIV   = 99000000,
    parameter int HOLD_STEPS = 3
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] pat,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           led
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = $clog2(HOLD_STEPS + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(HOLD_STEPS - 1);
    localparam logic [IW-1:0] RR_LAST   = IW'(NUM_REQ - 1);

    led_sched_state_t state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      step_q, step_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [1:0]         led_d;
    logic               busy_d, done_d;
    logic               win_valid, win_prio;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IW-1:0]      win_idx;
    logic               tick, abort;

    led_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req),
        .rr_ptr   (rr_q),
        .valid    (win_valid),
        .prio_win (win_prio),
        .onehot   (win_onehot),
        .idx      (win_idx)
    );

    assign tick  = (cnt_q == CNT_MAX);
    assign abort = ~|(req & grant);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        rr_d    = rr_q;
        grant_d = grant;
        led_d   = led;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                led_d = LED_IDLE;
                if (win_valid) begin
                    state_d = SHOW;
                    grant_d = win_onehot;
                    led_d   = pat[{win_idx, 1'b0} +: 2];
                    rr_d    = win_prio ? rr_q : (win_idx == RR_LAST ? '0 : win_idx + 1'b1);
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            SHOW: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                // A dropped request wins over a completing tick, so done never fires on an abort.
                if (abort || (tick && step_q == STEP_LAST)) begin
                    state_d = GAP;
                    grant_d = '0;
                    led_d   = LED_OFF;
                    cnt_d   = '0;
                    step_d  = '0;
                    done_d  = ~abort;
                end else if (tick) begin
                    step_d = step_q + 1'b1;
                    led_d  = rotl2(led);
                end
            end
            GAP: begin
                led_d   = tick ? LED_IDLE : LED_OFF;
                cnt_d   = tick ? '0 : cnt_q + 1'b1;
                state_d = tick ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            rr_q    <= '0;
            grant   <= '0;
            led     <= LED_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            rr_q    <= rr_d;
            grant   <= grant_d;
            led     <= led_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_led_req_scheduler.sv
// tb_led_req_scheduler: directed table-driven bench for led_req_scheduler (NUM_REQ=4, TICK_DIV=4, HOLD_STEPS=3)
module tb_led_req_scheduler;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] pat = '0;
    logic [3:0] grant;
    logic       busy, done;
    logic [1:0] led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] pat;
        logic [3:0] grant;
        logic [1:0] led;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tv[18];

    led_req_scheduler #(.NUM_REQ(4), .TICK_DIV(4), .HOLD_STEPS(3)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .req     (req),
        .pat     (pat),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .led     (led)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_grant(input bit nz, input string nm);
        int n = 0;
        while (((grant != 4'b0) != nz) && n < 40) begin
            cyc();
            n++;
        end
        if (n == 40) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for grant %s", nm, nz ? "set" : "clear");
        end
    endtask

    initial begin
        // Timeline rows: inputs driven before edge c, outputs checked after edge c (c = 1..18).
        // pat 8'h1B puts 01 at requester 2; 8'h30 puts 11 there to expose live-pattern leaks.
        tv[0]  = '{4'b0100, 8'h1B, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[1]  = '{4'b0100, 8'h30, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[2]  = '{4'b0100, 8'h30, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[3]  = '{4'b0100, 8'h30, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[4]  = '{4'b0100, 8'h30, 4'b0100, 2'b10, 1'b1, 1'b0};
        tv[5]  = '{4'b0100, 8'h30, 4'b0100, 2'b10, 1'b1, 1'b0};
        tv[6]  = '{4'b0100, 8'h30, 4'b0100, 2'b10, 1'b1, 1'b0};
        tv[7]  = '{4'b0100, 8'h30, 4'b0100, 2'b10, 1'b1, 1'b0};
        tv[8]  = '{4'b0100, 8'h30, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[9]  = '{4'b0100, 8'h30, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[10] = '{4'b0100, 8'h30, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[11] = '{4'b0100, 8'h30, 4'b0100, 2'b01, 1'b1, 1'b0};
        tv[12] = '{4'b0100, 8'h30, 4'b0000, 2'b00, 1'b1, 1'b1};
        tv[13] = '{4'b0100, 8'h30, 4'b0000, 2'b00, 1'b1, 1'b0};
        tv[14] = '{4'b0100, 8'h30, 4'b0000, 2'b00, 1'b1, 1'b0};
        tv[15] = '{4'b0100, 8'h30, 4'b0000, 2'b00, 1'b1, 1'b0};
        tv[16] = '{4'b0100, 8'h1B, 4'b0000, 2'b11, 1'b0, 1'b0};
        tv[17] = '{4'b0100, 8'h1B, 4'b0100, 2'b01, 1'b1, 1'b0};

        // Reset values
        sys_rst = 1'b1;
        cycn(2);
        chk("rst_led", 8'(led), 8'h03);
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        sys_rst = 1'b0;

        // Single requester: latency, rotation, completion, gap, re-grant
        for (int c = 0; c < 18; c++) begin
            req = tv[c].req;
            pat = tv[c].pat;
            cyc();
            chk($sformatf("t2_grant_c%0d", c + 1), 8'(grant), 8'(tv[c].grant));
            chk($sformatf("t2_led_c%0d", c + 1), 8'(led), 8'(tv[c].led));
            chk($sformatf("t2_busy_c%0d", c + 1), 8'(busy), 8'(tv[c].busy));
            chk($sformatf("t2_done_c%0d", c + 1), 8'(done), 8'(tv[c].done));
        end

        // All requesting: round-robin order (or fixed requester 0 with priority)
        sys_rst = 1'b1;
        req = 4'b1111;
        pat = 8'hE4;
        cyc();
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(1'b1, $sformatf("t3_g%0d", i));
`ifdef LED_SCHED_PRIO_EN
            chk($sformatf("t3_grant%0d", i), 8'(grant), 8'h01);
`else
            chk($sformatf("t3_grant%0d", i), 8'(grant), 8'(4'b0001 << (i % 4)));
`endif
            if (i < 4) begin
                wait_grant(1'b0, $sformatf("t3_r%0d", i));
                chk($sformatf("t3_done%0d", i), 8'(done), 8'h01);
            end
        end

        // Abort mid-grant
        sys_rst = 1'b1;
        req = 4'b0010;
        pat = 8'h08;
        cyc();
        sys_rst = 1'b0;
        cyc();
        chk("t4_grant_c1", 8'(grant), 8'h02);
        chk("t4_led_c1", 8'(led), 8'h02);
        cycn(5);
        req = 4'b0000;
        cyc();
        chk("t4_led_c7", 8'(led), 8'h00);
        chk("t4_grant_c7", 8'(grant), 8'h00);
        chk("t4_done_c7", 8'(done), 8'h00);
        chk("t4_busy_c7", 8'(busy), 8'h01);
        cycn(3);
        chk("t4_led_c10", 8'(led), 8'h00);
        cyc();
        chk("t4_led_c11", 8'(led), 8'h03);
        chk("t4_busy_c11", 8'(busy), 8'h00);

        // Abort coinciding with the completing tick: abort wins, no done
        sys_rst = 1'b1;
        req = 4'b0010;
        pat = 8'h08;
        cyc();
        sys_rst = 1'b0;
        cycn(12);
        chk("t4b_led_c12", 8'(led), 8'h02);
        req = 4'b0000;
        cyc();
        chk("t4b_done_c13", 8'(done), 8'h00);
        chk("t4b_grant_c13", 8'(grant), 8'h00);
        chk("t4b_led_c13", 8'(led), 8'h00);

        // Reset during SHOW clears rr_ptr
        sys_rst = 1'b1;
        req = 4'b0100;
        pat = 8'h00;
        cyc();
        sys_rst = 1'b0;
        cycn(6);
        chk("t5_grant_c6", 8'(grant), 8'h04);
        sys_rst = 1'b1;
        req = 4'b1111;
        cyc();
        chk("t5_led_rst", 8'(led), 8'h03);
        chk("t5_grant_rst", 8'(grant), 8'h00);
        chk("t5_busy_rst", 8'(busy), 8'h00);
        sys_rst = 1'b0;
        cyc();
        chk("t5_regrant", 8'(grant), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
